// File: rtl/lc3b_mem_responder_if.sv
// lc3b_mem_responder_if
// Memory-port bundle between the LC-3b datapath (master) and the memory
// responder (slave).
//   mem_read / mem_write : level requests, held until mem_resp
//   mem_address          : byte address (bit 0 ignored for word indexing)
//   mem_wdata            : write data
//   mem_byte_enable      : write lane mask, [1] -> [15:8], [0] -> [7:0]
//   mem_resp             : one-cycle completion pulse
//   mem_rdata            : read data, valid in the mem_resp cycle of a read
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
// Word-organised memory behind the LC-3b multicycle datapath memory port.
// Programmable wait-state latency, byte-lane write masking, single-cycle
// mem_resp pulse, and abort when the request is withdrawn mid-wait.
// Ports:
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : lc3b_mem_responder_if.slave memory port
//   rd_count : (LC3B_MEM_STATS_EN only) completed reads, saturating
//   wr_count : (LC3B_MEM_STATS_EN only) completed writes, saturating
// Parameters:
//   DEPTH_LOG2 : log2 of the number of 16-bit words (must be < 15)
//   LATENCY    : cycles from first sampled request to mem_resp, 1..15
// Optional feature macro: LC3B_MEM_STATS_EN
module lc3b_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lc3b_mem_responder_if.slave  bus
`ifdef LC3B_MEM_STATS_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // Counter preload so that WAIT lasts LATENCY-1 cycles before RESP.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           wdata_q;
  logic [1:0]            mask_q;
  logic                  resp_q;
  logic [15:0]           rdata_q;

  logic [15:0]           mem [DEPTH];

  logic                  req;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  addr_unused;

  assign req         = bus.mem_read | bus.mem_write;
  assign req_idx     = bus.mem_address[DEPTH_LOG2:1];
  // Bit 0 and the bits above the index only alias; they select nothing.
  assign addr_unused = ^{bus.mem_address[15:DEPTH_LOG2+1], bus.mem_address[0]};

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      op_wr    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_q <= 1'b0;
          if (req) begin
            // Both requests high is a write.
            op_wr   <= bus.mem_write;
            idx_q   <= req_idx;
            wdata_q <= bus.mem_wdata;
            mask_q  <= bus.mem_byte_enable;
            if (LATENCY == 1) begin
              state  <= S_RESP;
              resp_q <= 1'b1;
              if (!bus.mem_write) rdata_q <= mem[req_idx];
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state  <= S_RESP;
            resp_q <= 1'b1;
            if (!op_wr) rdata_q <= mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          resp_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          resp_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; a write commits on the edge that ends RESP, so a
  // reset that forces IDLE beforehand discards it.
  always_ff @(posedge clk) begin
    if (state == S_RESP && op_wr) begin
      if (mask_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
      if (mask_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
    end
  end

`ifdef LC3B_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == S_RESP) begin
      if (op_wr) begin
        if (wr_count != '1) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != '1) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;
  localparam int LAT = 3;
  localparam int DL2 = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3b_mem_responder_if bus ();

`ifdef LC3B_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  lc3b_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus)
`ifdef LC3B_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: byte-addressed store of known bytes, plus held read data.
  logic [7:0]  mbyte [int];
  logic [15:0] exp_rdata;
`ifdef LC3B_MEM_STATS_EN
  int exp_rd_n;
  int exp_wr_n;
`endif

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % (1 << DL2);
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [15:0] d,
                                      input logic [1:0] be);
    if (be[0]) mbyte[widx(a) * 2]     = d[7:0];
    if (be[1]) mbyte[widx(a) * 2 + 1] = d[15:8];
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] w;
    w = 16'hxxxx;
    if (mbyte.exists(widx(a) * 2))     w[7:0]  = mbyte[widx(a) * 2];
    if (mbyte.exists(widx(a) * 2 + 1)) w[15:8] = mbyte[widx(a) * 2 + 1];
    return w;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
  endtask

  // Full transaction: request in cycle 0, expect mem_resp only in cycle LAT,
  // then drop the request and confirm the pulse ended and rdata holds.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be,
                     input logic [15:0] exp, input string tag);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    drive(rd, wr, a, wd, be);
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, LAT);
    if (lat >= 0) begin
      chk({tag, "_rdata"}, bus.mem_rdata, exp);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      @(negedge clk);
      chk({tag, "_pulse_end"}, bus.mem_resp, 1'b0);
      chk({tag, "_rdata_hold"}, bus.mem_rdata, exp);
      if (wr) begin
        model_write(a, wd, be);
`ifdef LC3B_MEM_STATS_EN
        exp_wr_n++;
`endif
      end else begin
        exp_rdata = exp;
`ifdef LC3B_MEM_STATS_EN
        exp_rd_n++;
`endif
      end
    end else begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    end
  endtask

  // Request held for 'hold' cycles (< LAT), then withdrawn: no response.
  task automatic abort_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be,
                           input int hold, input string tag);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    drive(rd, wr, a, wd, be);
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c == hold) drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      @(negedge clk);
      if (bus.mem_resp !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    chk({tag, "_no_resp"}, seen, 0);
    chk({tag, "_rdata_kept"}, bus.mem_rdata, exp_rdata);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1;
    exp_rdata = 16'h0000;
`ifdef LC3B_MEM_STATS_EN
    exp_rd_n = 0;
    exp_wr_n = 0;
`endif
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    int          op;

    vecs[0]  = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, 16'h0000, "preload"};
    vecs[1]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hBEEF, "read_beef"};
    vecs[2]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, 16'hBEEF, "wr_1234"};
    vecs[3]  = '{1'b1, 1'b0, 16'h0041, 16'h0000, 2'b00, 16'h1234, "rd_odd_addr"};
    vecs[4]  = '{1'b0, 1'b1, 16'h0040, 16'hAB56, 2'b10, 16'h1234, "wr_hi_lane"};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hAB34, "rd_ab34"};
    vecs[6]  = '{1'b0, 1'b1, 16'h0040, 16'hFFCD, 2'b01, 16'hAB34, "wr_lo_lane"};
    vecs[7]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hABCD, "rd_abcd"};
    vecs[8]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 2'b00, 16'hABCD, "wr_no_lane"};
    vecs[9]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hABCD, "rd_unchanged"};
    vecs[10] = '{1'b1, 1'b1, 16'h0060, 16'h7777, 2'b11, 16'hABCD, "rd_wr_is_wr"};
    vecs[11] = '{1'b1, 1'b0, 16'h0060, 16'h0000, 2'b00, 16'h7777, "rd_7777"};
    vecs[12] = '{1'b1, 1'b0, 16'h2040, 16'h0000, 2'b00, 16'hABCD, "rd_alias"};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    exp_rdata = 16'h0000;
`ifdef LC3B_MEM_STATS_EN
    exp_rd_n = 0;
    exp_wr_n = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp", bus.mem_resp, 1'b0);
    chk("reset_rdata", bus.mem_rdata, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].exp, vecs[i].name);

    // Write withdrawn after one cycle leaves storage untouched.
    abort_txn(1'b0, 1'b1, 16'h0060, 16'h5555, 2'b11, 1, "abort_wr");
    txn(1'b1, 1'b0, 16'h0060, 16'h0, 2'b00, 16'h7777, "rd_after_abort");
    // Read withdrawn on the last wait cycle.
    abort_txn(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, LAT - 1, "abort_rd_late");

    // Reset during the WAIT of a write.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h0060, 16'h9999, 2'b11);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midreset_resp", bus.mem_resp, 1'b0);
    chk("midreset_rdata", bus.mem_rdata, 16'h0000);
    exp_rdata = 16'h0000;
`ifdef LC3B_MEM_STATS_EN
    exp_rd_n = 0;
    exp_wr_n = 0;
`endif
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    txn(1'b1, 1'b0, 16'h0060, 16'h0, 2'b00, 16'h7777, "rd_after_midreset");

    // Randomised phase: fill words 0..31, then mixed traffic with aliasing.
    for (int i = 0; i < 32; i++) begin
      a = 16'(i * 2);
      d = 16'($urandom);
      txn(1'b0, 1'b1, a, d, 2'b11, exp_rdata, "fill");
    end
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 9));
      a = 16'($urandom);
      a[12:1] = 12'($urandom_range(0, 31));
      d = 16'($urandom);
      be = 2'($urandom);
      if (op == 0)
        abort_txn(1'($urandom), 1'b1, a, d, be, int'($urandom_range(1, LAT - 1)), "rnd_abort");
      else if (op <= 4)
        txn(1'b1, 1'b0, a, d, be, model_read(a), "rnd_rd");
      else if (op <= 8)
        txn(1'b0, 1'b1, a, d, be, exp_rdata, "rnd_wr");
      else
        txn(1'b1, 1'b1, a, d, be, exp_rdata, "rnd_rdwr");
    end

`ifdef LC3B_MEM_STATS_EN
    chk("rnd_rd_count", rd_count, 16'(exp_rd_n));
    chk("rnd_wr_count", wr_count, 16'(exp_wr_n));
    do_reset();
    chk("stats_reset_rd", rd_count, 16'h0);
    chk("stats_reset_wr", wr_count, 16'h0);
    txn(1'b1, 1'b0, 16'h0002, 16'h0, 2'b00, model_read(16'h0002), "st_rd0");
    txn(1'b0, 1'b1, 16'h0004, 16'h1111, 2'b11, exp_rdata, "st_wr0");
    txn(1'b1, 1'b0, 16'h0004, 16'h0, 2'b00, 16'h1111, "st_rd1");
    abort_txn(1'b1, 1'b0, 16'h0004, 16'h0, 2'b00, 1, "st_abort");
    txn(1'b0, 1'b1, 16'h0006, 16'h2222, 2'b01, exp_rdata, "st_wr1");
    txn(1'b1, 1'b0, 16'h0006, 16'h0, 2'b00, model_read(16'h0006), "st_rd2");
    chk("stats_rd_count", rd_count, 16'd3);
    chk("stats_wr_count", wr_count, 16'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
